vxc_mul_add_seq: RTL and testbench

VXC_MUL_ADD_SEQ -- requirements
Module: vxc_mul_add_seq

---
 rtl/vxc_mul_add_seq.sv | 201 ++++++++++++++++++++
 tb/tb_vxc_mul_add_seq.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxc_mul_add_seq.sv
// Sequential vector engine: fetches chunks of a and b, computes a (+|-) c*b (or c*b, or a) per lane,
// and writes each result chunk with a per-lane valid mask.
//
// state  | meaning
// IDLE   | waiting for start; op and constant latched on start
// RD     | one-cycle read strobe for the current chunk
// WAIT   | RD_LAT cycles of memory latency; operands captured on the last edge
// CALC   | per-lane arithmetic and mask registered
// WR     | result held until wr_ready accepts it
// DONE   | one-cycle completion pulse

module vxc_mul_add_seq #(
    parameter int NUM_EQ = 16,
    parameter int NU     = 8,
    parameter int W      = 32,
    parameter int FRAC   = 0,
    parameter int RD_LAT = 2,
    parameter int SAT    = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [1:0]                             op,
    input  logic [W-1:0]                           constant,
    output logic                                   rd_en,
    output logic [$clog2((NUM_EQ+NU-1)/NU):0]      rd_addr,
    input  logic [NU*W-1:0]                        rd_data_a,
    input  logic [NU*W-1:0]                        rd_data_b,
    output logic                                   wr_en,
    input  logic                                   wr_ready,
    output logic [$clog2((NUM_EQ+NU-1)/NU):0]      wr_addr,
    output logic [NU*W-1:0]                        wr_data,
    output logic [NU-1:0]                          wr_mask,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CHUNKS = (NUM_EQ + NU - 1) / NU;
    localparam int AW     = $clog2(CHUNKS) + 1;
    localparam int CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int PW     = W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CALC,
        S_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       c_q, c_d;
    logic [NU*W-1:0]    a_q, a_d;
    logic [NU*W-1:0]    b_q, b_d;
    logic [NU*W-1:0]    wr_data_q, wr_data_d;
    logic [NU-1:0]      wr_mask_q, wr_mask_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NU*W-1:0]    calc_data;
    logic [NU-1:0]      calc_mask;

    // Product is formed at full 2W precision, floored by FRAC, then combined with a at W+2 bits.
    function automatic logic [W-1:0] lane_calc(input logic [1:0] f_op,
                                               input logic signed [W-1:0] f_c,
                                               input logic signed [W-1:0] f_a,
                                               input logic signed [W-1:0] f_b);
        logic signed [2*W-1:0] prod;
        logic signed [PW-1:0]  prod_s;
        logic signed [PW-1:0]  a_s;
        logic signed [PW-1:0]  res;
        prod   = f_c * f_b;
        prod_s = PW'(prod >>> FRAC);
        a_s    = PW'(f_a);
        case (f_op)
            2'b00:   res = a_s + prod_s;
            2'b01:   res = a_s - prod_s;
            2'b10:   res = prod_s;
            default: res = a_s;
        endcase
        if ((SAT != 0) && (res[PW-1:W-1] != '0) && (res[PW-1:W-1] != '1)) begin
            return res[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return res[W-1:0];
    endfunction

    always_comb begin
        calc_data = '0;
        calc_mask = '0;
        for (int k = 0; k < NU; k++) begin
            if (int'(idx_q) * NU + k < NUM_EQ) begin
                calc_mask[k]         = 1'b1;
                calc_data[k*W +: W]  = lane_calc(op_q, c_q, a_q[k*W +: W], b_q[k*W +: W]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    c_d     = constant;
                    idx_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                cnt_d   = CW'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    a_d     = rd_data_a;
                    b_d     = rd_data_b;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CALC: begin
                wr_data_d = calc_data;
                wr_mask_d = calc_mask;
                state_d   = S_WR;
            end
            S_WR: begin
                if (wr_ready) begin
                    if (idx_q == AW'(CHUNKS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so they line up with the state they belong to.
        rd_en_d = (state_d == S_RD);
        wr_en_d = (state_d == S_WR);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            c_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            c_q       <= c_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = idx_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = idx_q;
    assign wr_data = wr_data_q;
    assign wr_mask = wr_mask_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_vxc_mul_add_seq.sv
// Directed bench for vxc_mul_add_seq: three instances cover the default config, a ragged
// saturating config (NUM_EQ=20, SAT=1) and a fixed-point config (FRAC=16).

module tb_vxc_mul_add_seq;

    localparam int DW = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance 0: NUM_EQ=16, SAT=0, FRAC=0
    logic          start0, wr_ready0, rd_en0, wr_en0, busy0, done0;
    logic [1:0]    op0, rd_addr0, wr_addr0;
    logic [31:0]   c0;
    logic [DW-1:0] rda0, rdb0, wr_data0;
    logic [7:0]    wr_mask0;
    logic [DW-1:0] ma0 [0:3];
    logic [DW-1:0] mb0 [0:3];
    logic [1:0]    la0 = '0;
    logic [DW-1:0] wd0 [0:63];
    logic [7:0]    wm0 [0:63];
    int            wa0 [0:63];
    int            wcnt0 = 0;

    // instance 1: NUM_EQ=20, SAT=1
    logic          start1, wr_ready1, rd_en1, wr_en1, busy1, done1;
    logic [1:0]    op1;
    logic [2:0]    rd_addr1, wr_addr1;
    logic [31:0]   c1;
    logic [DW-1:0] rda1, rdb1, wr_data1;
    logic [7:0]    wr_mask1;
    logic [DW-1:0] ma1 [0:7];
    logic [DW-1:0] mb1 [0:7];
    logic [2:0]    la1 = '0;
    logic [DW-1:0] wd1 [0:63];
    logic [7:0]    wm1 [0:63];
    int            wa1 [0:63];
    int            wcnt1 = 0;

    // instance 2: NUM_EQ=8, FRAC=16
    logic          start2, wr_ready2, rd_en2, wr_en2, busy2, done2;
    logic [1:0]    op2;
    logic [0:0]    rd_addr2, wr_addr2;
    logic [31:0]   c2;
    logic [DW-1:0] rda2, rdb2, wr_data2;
    logic [7:0]    wr_mask2;
    logic [DW-1:0] ma2 [0:1];
    logic [DW-1:0] mb2 [0:1];
    logic [0:0]    la2 = '0;
    logic [DW-1:0] wd2 [0:63];
    int            wcnt2 = 0;

    vxc_mul_add_seq #(.NUM_EQ(16), .NU(8), .W(32), .FRAC(0), .RD_LAT(2), .SAT(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .op(op0), .constant(c0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data_a(rda0), .rd_data_b(rdb0),
        .wr_en(wr_en0), .wr_ready(wr_ready0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .wr_mask(wr_mask0), .busy(busy0), .done(done0));

    vxc_mul_add_seq #(.NUM_EQ(20), .NU(8), .W(32), .FRAC(0), .RD_LAT(2), .SAT(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .constant(c1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data_a(rda1), .rd_data_b(rdb1),
        .wr_en(wr_en1), .wr_ready(wr_ready1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_mask(wr_mask1), .busy(busy1), .done(done1));

    vxc_mul_add_seq #(.NUM_EQ(8), .NU(8), .W(32), .FRAC(16), .RD_LAT(2), .SAT(0)) u2 (
        .clk(clk), .reset(reset), .start(start2), .op(op2), .constant(c2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data_a(rda2), .rd_data_b(rdb2),
        .wr_en(wr_en2), .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .wr_mask(wr_mask2), .busy(busy2), .done(done2));

    // memories: address latched on the strobe, data held until the next strobe
    always @(posedge clk) if (rd_en0) la0 <= rd_addr0;
    always @(posedge clk) if (rd_en1) la1 <= rd_addr1;
    always @(posedge clk) if (rd_en2) la2 <= rd_addr2;
    assign rda0 = ma0[la0];
    assign rdb0 = mb0[la0];
    assign rda1 = ma1[la1];
    assign rdb1 = mb1[la1];
    assign rda2 = ma2[la2];
    assign rdb2 = mb2[la2];

    always @(posedge clk) if (wr_en0 && wr_ready0 && wcnt0 < 64) begin
        wd0[wcnt0] <= wr_data0; wm0[wcnt0] <= wr_mask0; wa0[wcnt0] <= int'(wr_addr0);
        wcnt0 <= wcnt0 + 1;
    end
    always @(posedge clk) if (wr_en1 && wr_ready1 && wcnt1 < 64) begin
        wd1[wcnt1] <= wr_data1; wm1[wcnt1] <= wr_mask1; wa1[wcnt1] <= int'(wr_addr1);
        wcnt1 <= wcnt1 + 1;
    end
    always @(posedge clk) if (wr_en2 && wr_ready2 && wcnt2 < 64) begin
        wd2[wcnt2] <= wr_data2;
        wcnt2 <= wcnt2 + 1;
    end

    // stimulus helper: start one op on instance u, wait for done, then step into IDLE
    task automatic run(input int u, input logic [1:0] op, input logic [31:0] c,
                       output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        case (u)
            0:       begin op0 = op; c0 = c; start0 = 1'b1; end
            1:       begin op1 = op; c1 = c; start1 = 1'b1; end
            default: begin op2 = op; c2 = c; start2 = 1'b1; end
        endcase
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
            if ((u == 0 && done0) || (u == 1 && done1) || (u == 2 && done2)) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_basic0();
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 8; k++) begin
                ma0[w][k*32 +: 32] = 32'(w * 8 + k);
                mb0[w][k*32 +: 32] = 32'd1;
            end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy0, done0, rd_en0, wr_en0, rd_addr0, wr_mask0} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0", {busy0, done0, rd_en0, wr_en0, rd_addr0, wr_mask0});
        end
        checks++;
        if (wr_data0 !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", wr_data0); end
        checks++;
        if ({busy1, busy2, done1, done2} !== 4'd0) begin
            errors++; $display("FAIL reset_busy_others got %b exp 0000", {busy1, busy2, done1, done2});
        end
    endtask

    task automatic test_basic();
        int cyc; bit to; int snap; logic [DW-1:0] exp;
        fill_basic0();
        wr_ready0 = 1'b1;
        snap = wcnt0;
        run(0, 2'b00, 32'd3, cyc, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", cyc); end
        checks++;
        if (wcnt0 - snap != 2) begin errors++; $display("FAIL basic_nwrites got %0d exp 2", wcnt0 - snap); end
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(w * 8 + k + 3);
            checks++;
            if (wa0[snap+w] != w) begin errors++; $display("FAIL basic_addr%0d got %0d exp %0d", w, wa0[snap+w], w); end
            checks++;
            if (wm0[snap+w] !== 8'hFF) begin errors++; $display("FAIL basic_mask%0d got %h exp ff", w, wm0[snap+w]); end
            checks++;
            if (wd0[snap+w] !== exp) begin errors++; $display("FAIL basic_data%0d got %h exp %h", w, wd0[snap+w], exp); end
        end
    endtask

    task automatic test_ops();
        int cyc; bit to; int snap; int cval; int v; logic [DW-1:0] exp;
        fill_basic0();
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 8; k++) mb0[w][k*32 +: 32] = 32'(k - 4);
        for (int t = 1; t < 4; t++) begin
            cval = (t == 1) ? 5 : (t == 2) ? -3 : 7;
            snap = wcnt0;
            run(0, 2'(t), 32'(cval), cyc, to);
            for (int w = 0; w < 2; w++) begin
                for (int k = 0; k < 8; k++) begin
                    case (t)
                        1:       v = (w * 8 + k) - 5 * (k - 4);
                        2:       v = -3 * (k - 4);
                        default: v = w * 8 + k;
                    endcase
                    exp[k*32 +: 32] = 32'(v);
                end
                checks++;
                if (wd0[snap+w] !== exp) begin
                    errors++; $display("FAIL op%0d_data%0d got %h exp %h", t, w, wd0[snap+w], exp);
                end
            end
        end
        // wrap without saturation
        fill_basic0();
        ma0[0][31:0] = 32'h7FFF_FFF0;
        mb0[0][31:0] = 32'h0000_0010;
        snap = wcnt0;
        run(0, 2'b00, 32'd2, cyc, to);
        checks++;
        if (wd0[snap][31:0] !== 32'h8000_0010) begin
            errors++; $display("FAIL wrap_lane0 got %h exp 80000010", wd0[snap][31:0]);
        end
    endtask

    task automatic test_chunks();
        int cyc; bit to; int snap; logic [DW-1:0] exp;
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < 8; k++) begin
                ma1[w][k*32 +: 32] = 32'(w * 8 + k);
                mb1[w][k*32 +: 32] = 32'd1;
            end
        snap = wcnt1;
        run(1, 2'b00, 32'd3, cyc, to);
        checks++;
        if (to || cyc != 16) begin errors++; $display("FAIL chunks_latency got %0d exp 16", cyc); end
        checks++;
        if (wcnt1 - snap != 3) begin errors++; $display("FAIL chunks_nwrites got %0d exp 3", wcnt1 - snap); end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (wa1[snap+w] != w) begin errors++; $display("FAIL chunks_addr%0d got %0d exp %0d", w, wa1[snap+w], w); end
        end
        checks++;
        if (wm1[snap+1] !== 8'hFF) begin errors++; $display("FAIL chunks_mask1 got %h exp ff", wm1[snap+1]); end
        checks++;
        if (wm1[snap+2] !== 8'h0F) begin errors++; $display("FAIL chunks_mask2 got %h exp 0f", wm1[snap+2]); end
        for (int k = 0; k < 8; k++) exp[k*32 +: 32] = (k < 4) ? 32'(16 + k + 3) : 32'd0;
        checks++;
        if (wd1[snap+2] !== exp) begin errors++; $display("FAIL chunks_last_data got %h exp %h", wd1[snap+2], exp); end
    endtask

    task automatic test_sat();
        int cyc; bit to; int snap;
        ma1[0][31:0]  = 32'h7FFF_FFF0;  mb1[0][31:0]  = 32'h0000_0010;
        ma1[0][63:32] = 32'h8000_0010;  mb1[0][63:32] = 32'h0000_0010;
        snap = wcnt1;
        run(1, 2'b00, 32'd2, cyc, to);
        checks++;
        if (wd1[snap][31:0] !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL sat_max got %h exp 7fffffff", wd1[snap][31:0]);
        end
        snap = wcnt1;
        run(1, 2'b01, 32'd2, cyc, to);
        checks++;
        if (wd1[snap][63:32] !== 32'h8000_0000) begin
            errors++; $display("FAIL sat_min got %h exp 80000000", wd1[snap][63:32]);
        end
        checks++;
        if (wd1[snap][31:0] !== 32'h7FFF_FFD0) begin
            errors++; $display("FAIL sat_inrange got %h exp 7fffffd0", wd1[snap][31:0]);
        end
    endtask

    task automatic test_frac();
        int cyc; bit to; int snap;
        ma2[0] = '0; mb2[0] = '0; ma2[1] = '0; mb2[1] = '0;
        ma2[0][31:0]  = 32'h0003_0000;  mb2[0][31:0]  = 32'h0002_0000;
        ma2[0][63:32] = 32'h0000_0000;  mb2[0][63:32] = 32'hFFFF_FFFF;
        snap = wcnt2;
        run(2, 2'b01, 32'h0000_8000, cyc, to);
        checks++;
        if (to || cyc != 6) begin errors++; $display("FAIL frac_latency got %0d exp 6", cyc); end
        checks++;
        if (wd2[snap][31:0] !== 32'h0002_0000) begin
            errors++; $display("FAIL frac_sub got %h exp 00020000", wd2[snap][31:0]);
        end
        checks++;
        if (wd2[snap][63:32] !== 32'h0000_0001) begin
            errors++; $display("FAIL frac_floor_sub got %h exp 00000001", wd2[snap][63:32]);
        end
        snap = wcnt2;
        run(2, 2'b10, 32'h0000_8000, cyc, to);
        checks++;
        if (wd2[snap][63:0] !== 64'hFFFF_FFFF_0001_0000) begin
            errors++; $display("FAIL frac_mul got %h exp ffffffff00010000", wd2[snap][63:0]);
        end
    endtask

    task automatic test_stall();
        int cyc; int snap; int held; int done_cyc; bit stable; bit rd_during;
        logic [DW-1:0] first_d; logic [DW-1:0] exp;
        fill_basic0();
        snap = wcnt0; held = 0; done_cyc = 0; stable = 1'b1; rd_during = 1'b0; cyc = 0;
        first_d = '0;
        wr_ready0 = 1'b0; op0 = 2'b00; c0 = 32'd3; start0 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            start0 = 1'b0;
            if (held > 0 && wcnt0 == snap && rd_en0) rd_during = 1'b1;
            if (wr_en0 && wcnt0 == snap) begin
                if (held == 0) first_d = wr_data0;
                else if (wr_data0 !== first_d || wr_mask0 !== 8'hFF || wr_addr0 !== 2'd0) stable = 1'b0;
                held++;
            end
            wr_ready0 = (held >= 6);
            if (done0) begin done_cyc = cyc; break; end
        end
        wr_ready0 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (held != 6) begin errors++; $display("FAIL stall_hold got %0d exp 6", held); end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_stable got changed exp stable"); end
        checks++;
        if (rd_during) begin errors++; $display("FAIL stall_rd_en got 1 exp 0"); end
        checks++;
        if (done_cyc != 16) begin errors++; $display("FAIL stall_latency got %0d exp 16", done_cyc); end
        for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k + 3);
        checks++;
        if (wd0[snap] !== exp) begin errors++; $display("FAIL stall_data got %h exp %h", wd0[snap], exp); end
    endtask

    task automatic test_reset_mid();
        int snap; bit found; bit activity;
        fill_basic0();
        found = 1'b0; activity = 1'b0;
        op0 = 2'b00; c0 = 32'd3; start0 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start0 = 1'b0;
            if (rd_en0 && rd_addr0 == 2'd1) begin found = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        snap = wcnt0;
        reset = 1'b1;
        #1;
        checks++;
        if (!found || busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy0); end
        checks++;
        if ({rd_en0, wr_en0, done0, rd_addr0} !== 5'd0) begin
            errors++; $display("FAIL midreset_ctrl got %b exp 0", {rd_en0, wr_en0, done0, rd_addr0});
        end
        checks++;
        if (wr_data0 !== '0 || wr_mask0 !== 8'h00) begin
            errors++; $display("FAIL midreset_data got %h/%h exp 0/0", wr_data0, wr_mask0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (wr_en0 || busy0 || rd_en0) activity = 1'b1;
        end
        checks++;
        if (activity || wcnt0 != snap) begin
            errors++; $display("FAIL midreset_abandon got activity=%b writes=%0d exp 0/0", activity, wcnt0 - snap);
        end
    endtask

    task automatic test_back_to_back();
        int snap; bit seen; logic [DW-1:0] exp;
        fill_basic0();
        snap = wcnt0; seen = 1'b0;
        op0 = 2'b00; c0 = 32'd3; start0 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            op0 = 2'b11; c0 = 32'd99;
            if (done0) begin seen = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        checks++;
        if (!seen || busy0 !== 1'b0) begin errors++; $display("FAIL b2b_done_start got busy=%b exp 0", busy0); end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_idle_start got busy=%b exp 1", busy0); end
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done0) break;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k + 3);
        checks++;
        if (wd0[snap] !== exp) begin errors++; $display("FAIL b2b_latched_op got %h exp %h", wd0[snap], exp); end
        for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k);
        checks++;
        if (wd0[snap+2] !== exp) begin errors++; $display("FAIL b2b_second_op got %h exp %h", wd0[snap+2], exp); end
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        op0 = '0; op1 = '0; op2 = '0;
        c0 = '0; c1 = '0; c2 = '0;
        wr_ready0 = 1'b1; wr_ready1 = 1'b1; wr_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_ops();
        test_chunks();
        test_sat();
        test_frac();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
